// File: rtl/chess_quiz_core.sv
// chess_quiz_core: turn-based board-square quiz with LFSR targets, per-turn countdown and per-player scores
module chess_quiz_core #(
  parameter int NUM_PLAYERS = 2,
  parameter int ROUNDS = 8,
  parameter int TIME_W = 8,
  parameter int TIME_LIMIT = 200,
  parameter int SCORE_W = 7,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           iniciar,
  input  logic                           jogada_valida,
  input  logic [2:0]                     jogadaLinha,
  input  logic [2:0]                     jogadaColuna,
  input  logic                           tick,
  output logic [2:0]                     linhaGerada,
  output logic [2:0]                     colunaGerada,
  output logic                           salvaNova,
  output logic [1:0]                     jogadorAtual,
  output logic [NUM_PLAYERS*SCORE_W-1:0] pontos,
  output logic [TIME_W-1:0]              tempoRestante,
  output logic                           acertou,
  output logic                           errou,
  output logic                           timeout,
  output logic                           fimJogo,
  output logic [3:0]                     db_estado
);
  typedef enum logic [3:0] {INICIAL, PREPARA, GERA, ESPERA, COMPARA, PROXIMO, FIM} estadoT;
  localparam logic [1:0] ULTIMO_JOGADOR = 2'(NUM_PLAYERS - 1);
  localparam logic [7:0] ULTIMA_RODADA = 8'(ROUNDS - 1);
  estadoT estado, proxEstado;
  logic [7:0] lfsr, rodada;
  logic [1:0] tentativas;
  logic [2:0] respLinha, respColuna;
  logic expirou, aceita, acerto, ultimo;
  assign aceita = lfsr[5:0] != {linhaGerada, colunaGerada} || tentativas == 2'd2;
  assign acerto = {respLinha, respColuna} == {linhaGerada, colunaGerada};
  assign ultimo = jogadorAtual == ULTIMO_JOGADOR;
  // State register
  always_ff @(posedge clock or posedge reset)
    if (reset) estado <= INICIAL;
    else estado <= proxEstado;
  // Next-state logic; iniciar only restarts from INICIAL, ESPERA or FIM, and an answer beats an expiring tick
  always_comb begin
    proxEstado = estado;
    case (estado)
      INICIAL: proxEstado = iniciar ? PREPARA : INICIAL;
      PREPARA: proxEstado = GERA;
      GERA:    proxEstado = aceita ? ESPERA : GERA;
      ESPERA:  proxEstado = iniciar ? PREPARA : jogada_valida ? COMPARA :
                            (tick && tempoRestante == TIME_W'(1)) ? PROXIMO : ESPERA;
      COMPARA: proxEstado = PROXIMO;
      PROXIMO: proxEstado = (ultimo && rodada == ULTIMA_RODADA) ? FIM : GERA;
      FIM:     proxEstado = iniciar ? PREPARA : FIM;
      default: proxEstado = INICIAL;
    endcase
  end
  // Outputs decoded from the state; the timeout pulse comes from a flag set as the turn expires
  always_comb begin
    salvaNova = estado == GERA && aceita;
    acertou = estado == COMPARA && acerto;
    errou = (estado == COMPARA && !acerto) || expirou;
    timeout = expirou;
    fimJogo = estado == FIM;
    db_estado = estado;
  end
  // Datapath: LFSR, target, countdown, answer latch, scores, player and round counters
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lfsr <= LFSR_SEED;
      rodada <= '0;
      tentativas <= '0;
      respLinha <= '0;
      respColuna <= '0;
      expirou <= 1'b0;
      linhaGerada <= '0;
      colunaGerada <= '0;
      jogadorAtual <= '0;
      pontos <= '0;
      tempoRestante <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      expirou <= estado == ESPERA && !iniciar && !jogada_valida && tick && tempoRestante == TIME_W'(1);
      tentativas <= (estado == GERA && !aceita) ? tentativas + 2'd1 : 2'd0;
      if (estado == PREPARA) begin
        pontos <= '0;
        rodada <= '0;
        jogadorAtual <= '0;
      end
      if (estado == GERA && aceita) begin
        linhaGerada <= lfsr[5:3];
        colunaGerada <= lfsr[2:0];
        tempoRestante <= TIME_W'(TIME_LIMIT);
      end
      if (estado == ESPERA && !iniciar) begin
        if (jogada_valida) begin
          respLinha <= jogadaLinha;
          respColuna <= jogadaColuna;
        end else if (tick && tempoRestante != '0) tempoRestante <= tempoRestante - TIME_W'(1);
      end
      for (int p = 0; p < NUM_PLAYERS; p++)
        if (estado == COMPARA && acerto && jogadorAtual == 2'(p) && pontos[p*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}})
          pontos[p*SCORE_W +: SCORE_W] <= pontos[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
      if (estado == PROXIMO) begin
        jogadorAtual <= ultimo ? 2'd0 : jogadorAtual + 2'd1;
        if (ultimo) rodada <= rodada + 8'd1;
      end
    end
endmodule

// File: tb/tb_chess_quiz_core.sv
// tb_chess_quiz_core: scoreboard bench for chess_quiz_core across two parameter sets
module tb_chess_quiz_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ini [2], jv [2], tk [2], salva [2], acert [2], err [2], tout [2], fim [2];
  logic [2:0] jl [2], jc [2], lin [2], col [2];
  logic [1:0] jog [2];
  logic [7:0] tempo [2];
  logic [3:0] est [2];
  logic [3:0] pontosA;
  logic [13:0] pontosB;
  logic [7:0] mdl;
  logic [5:0] tgt [2];
  logic [3:0] expQ [$];
  logic [3:0] expd;
  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  chess_quiz_core #(.SCORE_W(2)) dutA (
    .clock(clk), .reset(rst), .iniciar(ini[0]), .jogada_valida(jv[0]), .jogadaLinha(jl[0]),
    .jogadaColuna(jc[0]), .tick(tk[0]), .linhaGerada(lin[0]), .colunaGerada(col[0]),
    .salvaNova(salva[0]), .jogadorAtual(jog[0]), .pontos(pontosA), .tempoRestante(tempo[0]),
    .acertou(acert[0]), .errou(err[0]), .timeout(tout[0]), .fimJogo(fim[0]), .db_estado(est[0]));

  chess_quiz_core #(.ROUNDS(2), .TIME_LIMIT(3)) dutB (
    .clock(clk), .reset(rst), .iniciar(ini[1]), .jogada_valida(jv[1]), .jogadaLinha(jl[1]),
    .jogadaColuna(jc[1]), .tick(tk[1]), .linhaGerada(lin[1]), .colunaGerada(col[1]),
    .salvaNova(salva[1]), .jogadorAtual(jog[1]), .pontos(pontosB), .tempoRestante(tempo[1]),
    .acertou(acert[1]), .errou(err[1]), .timeout(tout[1]), .fimJogo(fim[1]), .db_estado(est[1]));

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4
  always @(posedge clk or posedge rst)
    if (rst) mdl <= 8'hA5;
    else mdl <= {mdl[6:0], mdl[7] ^ mdl[5] ^ mdl[4] ^ mdl[3]};

  // Scoreboard: every acertou/errou/timeout pulse pops the expected {dut, acertou, errou, timeout}
  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 2; d++)
        if (acert[d] || err[d] || tout[d]) begin
          nCmp++;
          if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL sb_unexpected dut%0d got a/e/t=%b%b%b with nothing expected", d, acert[d], err[d], tout[d]);
          end else begin
            expd = expQ.pop_front();
            if ({1'(d), acert[d], err[d], tout[d]} !== expd) begin
              nBad++;
              $display("FAIL sb_result got %b want %b", {1'(d), acert[d], err[d], tout[d]}, expd);
            end
          end
        end

  function automatic int score(input int d, input int p);
    return d == 0 ? int'(pontosA[p*2 +: 2]) : int'(pontosB[p*7 +: 7]);
  endfunction

  function automatic logic [38:0] outs(input int d);
    return {est[d], salva[d], acert[d], err[d], tout[d], fim[d], tempo[d], jog[d], lin[d], col[d],
            (d == 0) ? {10'd0, pontosA} : pontosB};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ini(input int d);
    cyc();
    ini[d] = 1'b1;
    cyc();
    ini[d] = 1'b0;
  endtask

  task automatic tick_once(input int d);
    cyc();
    tk[d] = 1'b1;
    cyc();
    tk[d] = 1'b0;
  endtask

  // Follows GERA: each cycle salvaNova must match the retry rule, then the target and timer load
  task automatic wait_target(input int d);
    int tries = 0;
    bit done = 1'b0;
    logic want;
    logic [5:0] cand = '0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (est[d] == 4'd2) begin
        cand = mdl[5:0];
        want = cand != {lin[d], col[d]} || tries == 2;
        nCmp++;
        if (salva[d] !== want) begin
          nBad++;
          $display("FAIL gera_salvaNova dut%0d got %b want %b", d, salva[d], want);
        end
        done = want;
        if (!want) tries++;
      end
    end
    nCmp++;
    if (!done) begin
      nBad++;
      $display("FAIL gera_wait dut%0d got no target within 8 cycles want one", d);
    end
    @(negedge clk);
    nCmp++;
    if ({lin[d], col[d], est[d], tempo[d]} !== {cand, 4'd3, 8'(d == 0 ? 200 : 3)}) begin
      nBad++;
      $display("FAIL target_load dut%0d got %h/%0d/%0d want %h/3/%0d", d, {lin[d], col[d]}, est[d], tempo[d], cand, d == 0 ? 200 : 3);
    end
    tgt[d] = cand;
  endtask

  // Drives one answer (optionally with a tick), queues its expected verdict, checks COMPARA follows
  task automatic answer(input int d, input logic [2:0] r, input logic [2:0] c, input logic t);
    cyc();
    jl[d] = r;
    jc[d] = c;
    jv[d] = 1'b1;
    tk[d] = t;
    expQ.push_back({1'(d), {r, c} == tgt[d], {r, c} != tgt[d], 1'b0});
    cyc();
    jv[d] = 1'b0;
    tk[d] = 1'b0;
    @(negedge clk);
    nCmp++;
    if (est[d] !== 4'd4) begin
      nBad++;
      $display("FAIL answer_latency dut%0d state got %0d want 4", d, est[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (outs(d) !== '0) begin
        nBad++;
        $display("FAIL reset_outputs dut%0d got %h want 0", d, outs(d));
      end
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_start();
    cyc();
    ini[0] = 1'b1;
    @(negedge clk);
    nCmp++;
    if (est[0] !== 4'd0) begin
      nBad++;
      $display("FAIL start_inicial got %0d want 0", est[0]);
    end
    cyc();
    ini[0] = 1'b0;
    @(negedge clk);
    nCmp++;
    if (est[0] !== 4'd1) begin
      nBad++;
      $display("FAIL start_prepara got %0d want 1", est[0]);
    end
    wait_target(0);
    nCmp++;
    if (jog[0] !== 2'd0) begin
      nBad++;
      $display("FAIL start_player got %0d want 0", jog[0]);
    end
  endtask

  task automatic test_correct();
    answer(0, tgt[0][5:3], tgt[0][2:0], 1'b0);
    @(negedge clk);
    nCmp++;
    if (est[0] !== 4'd5 || score(0, 0) != 1) begin
      nBad++;
      $display("FAIL correct_score got state %0d score %0d want 5 1", est[0], score(0, 0));
    end
    wait_target(0);
    nCmp++;
    if (jog[0] !== 2'd1) begin
      nBad++;
      $display("FAIL correct_next_player got %0d want 1", jog[0]);
    end
  endtask

  task automatic test_wrong();
    answer(0, tgt[0][5:3] + 3'd1, tgt[0][2:0], 1'b0);
    @(negedge clk);
    nCmp++;
    if (score(0, 0) != 1 || score(0, 1) != 0) begin
      nBad++;
      $display("FAIL wrong_scores got %0d,%0d want 1,0", score(0, 0), score(0, 1));
    end
    wait_target(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      answer(0, tgt[0][5:3], tgt[0][2:0], 1'b0);
      wait_target(0);
    end
    nCmp++;
    if (score(0, 0) != 3 || score(0, 1) != 3 || jog[0] !== 2'd0 || fim[0] !== 1'b0) begin
      nBad++;
      $display("FAIL saturate got %0d,%0d player %0d fim %b want 3,3 player 0 fim 0", score(0, 0), score(0, 1), jog[0], fim[0]);
    end
  endtask

  task automatic test_restart();
    pulse_ini(0);
    @(negedge clk);
    nCmp++;
    if (est[0] !== 4'd1) begin
      nBad++;
      $display("FAIL restart_state got %0d want 1", est[0]);
    end
    wait_target(0);
    nCmp++;
    if (score(0, 0) != 0 || score(0, 1) != 0 || jog[0] !== 2'd0) begin
      nBad++;
      $display("FAIL restart_clear got %0d,%0d player %0d want 0,0,0", score(0, 0), score(0, 1), jog[0]);
    end
  endtask

  task automatic test_timeout();
    pulse_ini(1);
    wait_target(1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      tk[1] = 1'b1;
      if (i == 2) expQ.push_back(4'b1011);
      cyc();
      tk[1] = 1'b0;
      @(negedge clk);
      nCmp++;
      if (tempo[1] !== 8'(2 - i)) begin
        nBad++;
        $display("FAIL timeout_count got %0d want %0d", tempo[1], 2 - i);
      end
    end
    nCmp++;
    if (est[1] !== 4'd5 || score(1, 0) != 0) begin
      nBad++;
      $display("FAIL timeout_state got %0d score %0d want 5 0", est[1], score(1, 0));
    end
    wait_target(1);
  endtask

  task automatic test_tick_race();
    tick_once(1);
    tick_once(1);
    answer(1, tgt[1][5:3], tgt[1][2:0], 1'b1);
    nCmp++;
    if (tempo[1] !== 8'd1) begin
      nBad++;
      $display("FAIL race_timer got %0d want 1", tempo[1]);
    end
    @(negedge clk);
    nCmp++;
    if (score(1, 1) != 1) begin
      nBad++;
      $display("FAIL race_score got %0d want 1", score(1, 1));
    end
    wait_target(1);
  endtask

  task automatic test_game_over();
    answer(1, tgt[1][5:3], tgt[1][2:0], 1'b0);
    wait_target(1);
    answer(1, tgt[1][5:3], tgt[1][2:0] + 3'd1, 1'b0);
    repeat (2) @(negedge clk);
    nCmp++;
    if (est[1] !== 4'd6 || fim[1] !== 1'b1) begin
      nBad++;
      $display("FAIL gameover_state got %0d fim %b want 6 1", est[1], fim[1]);
    end
    repeat (3) @(negedge clk);
    nCmp++;
    if (fim[1] !== 1'b1 || score(1, 0) != 1 || score(1, 1) != 1 || {lin[1], col[1]} !== tgt[1]) begin
      nBad++;
      $display("FAIL gameover_hold got fim %b scores %0d,%0d target %h want 1 1,1 %h", fim[1], score(1, 0), score(1, 1), {lin[1], col[1]}, tgt[1]);
    end
    pulse_ini(1);
    wait_target(1);
    nCmp++;
    if (fim[1] !== 1'b0 || pontosB !== 14'd0 || jog[1] !== 2'd0) begin
      nBad++;
      $display("FAIL newgame_clear got fim %b pontos %h player %0d want 0 0 0", fim[1], pontosB, jog[1]);
    end
  endtask

  task automatic test_async_reset();
    answer(0, tgt[0][5:3], tgt[0][2:0], 1'b0);
    wait_target(0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (outs(d) !== '0) begin
        nBad++;
        $display("FAIL async_reset dut%0d got %h want 0", d, outs(d));
      end
    end
    cyc();
    cyc();
    rst = 1'b0;
    pulse_ini(0);
    wait_target(0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ini[d] = 1'b0;
      jv[d] = 1'b0;
      tk[d] = 1'b0;
      jl[d] = '0;
      jc[d] = '0;
      tgt[d] = '0;
    end
    test_reset();
    test_start();
    test_correct();
    test_wrong();
    test_back_to_back();
    test_restart();
    test_timeout();
    test_tick_race();
    test_game_over();
    test_async_reset();
    repeat (2) @(negedge clk);
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL sb_drain got %0d pending want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
